// File: rtl/l15_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | l15_mem_responder                                                        |
// | Memory-side L1.5 responder: one request at a time from a word array.     |
// | Optional macro L15_RSP_DELAY_EN inserts RespDelay cycles before return.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module l15_mem_responder #(
  parameter int unsigned MemWords      = 4096,
  parameter bit          SwapEndianess = 1'b1,
  parameter int unsigned RespDelay     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_val_i,
  input  logic [4:0]  req_rqtype_i,
  input  logic [2:0]  req_size_i,
  input  logic [1:0]  req_threadid_i,
  input  logic [39:0] req_address_i,
  input  logic [63:0] req_data_i,
  output logic        req_ack_o,
  output logic        req_header_ack_o,
  output logic        rtrn_val_o,
  output logic [3:0]  rtrn_returntype_o,
  output logic [1:0]  rtrn_threadid_o,
  output logic [63:0] rtrn_data_0_o,
  output logic [63:0] rtrn_data_1_o,
  output logic [63:0] rtrn_data_2_o,
  output logic [63:0] rtrn_data_3_o,
  input  logic        rtrn_ack_i,
  output logic        err_o
);

  localparam int unsigned IdxW = $clog2(MemWords);

  localparam logic [4:0] RQ_LOAD   = 5'b00000;
  localparam logic [4:0] RQ_IMISS  = 5'b10000;
  localparam logic [4:0] RQ_STORE  = 5'b00001;
  localparam logic [3:0] RT_LOAD   = 4'b0000;
  localparam logic [3:0] RT_IFILL  = 4'b0001;
  localparam logic [3:0] RT_ST_ACK = 4'b0100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_ACCESS,
`ifdef L15_RSP_DELAY_EN
    S_DELAY,
`endif
    S_RESP
  } state_e;

  state_e               state_q, state_d;
  logic [4:0]           rqtype_q, rqtype_d;
  logic [2:0]           size_q, size_d;
  logic [1:0]           tid_q, tid_d;
  logic [IdxW+2:0]      addr_q, addr_d;
  logic [63:0]          wdata_q, wdata_d;
  logic                 err_q, err_d;
  logic [3:0][63:0]     rdata_q, rdata_d;
`ifdef L15_RSP_DELAY_EN
  logic [7:0]           cnt_q, cnt_d;
`else
  logic [7:0]           unused_delay;
  assign unused_delay = 8'(RespDelay);
`endif

  logic [63:0]          mem [MemWords];
  logic                 req_ack;
  logic                 rtrn_val;
  logic                 mem_we;
  logic [7:0]           be;
  logic [IdxW-1:0]      idx;
  logic [63:0]          wdata_lanes;
  logic                 unsupported;
  logic [3:0]           rtype;
  logic                 unused_addr;

  // Upper address bits only alias onto the array, so they are dropped.
  assign unused_addr = ^req_address_i[39:IdxW+3];

  function automatic logic [63:0] endian_fix(input logic [63:0] w);
    logic [63:0] r;
    r = w;
    if (SwapEndianess) begin
      for (int b = 0; b < 8; b++) r[8*b +: 8] = w[8*(7-b) +: 8];
    end
    return r;
  endfunction

  assign idx         = addr_q[IdxW+2:3];
  assign wdata_lanes = endian_fix(wdata_q);
  assign unsupported = !(rqtype_q inside {RQ_LOAD, RQ_IMISS, RQ_STORE});

  // Misaligned low address bits are masked down to the access size.
  always_comb begin
    be = 8'h00;
    case (size_q)
      3'd0:    be = 8'b0000_0001 << addr_q[2:0];
      3'd1:    be = 8'b0000_0011 << {addr_q[2:1], 1'b0};
      3'd2:    be = 8'b0000_1111 << {addr_q[2], 2'b00};
      default: be = 8'hFF;
    endcase
  end

  always_comb begin
    case (rqtype_q)
      RQ_LOAD:  rtype = RT_LOAD;
      RQ_IMISS: rtype = RT_IFILL;
      default:  rtype = RT_ST_ACK;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rqtype_d = rqtype_q;
    size_d   = size_q;
    tid_d    = tid_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
`ifdef L15_RSP_DELAY_EN
    cnt_d    = cnt_q;
`endif
    req_ack  = 1'b0;
    rtrn_val = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_val_i) begin
          rqtype_d = req_rqtype_i;
          size_d   = req_size_i;
          tid_d    = req_threadid_i;
          addr_d   = req_address_i[IdxW+2:0];
          wdata_d  = req_data_i;
          state_d  = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        req_ack = 1'b1;
        mem_we  = (rqtype_q == RQ_STORE);
        if (unsupported) err_d = 1'b1;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        rdata_d = '0;
        if (rqtype_q == RQ_LOAD) begin
          rdata_d[0] = endian_fix(mem[{idx[IdxW-1:1], 1'b0}]);
          rdata_d[1] = endian_fix(mem[{idx[IdxW-1:1], 1'b1}]);
        end else if (rqtype_q == RQ_IMISS) begin
          rdata_d[0] = endian_fix(mem[{idx[IdxW-1:2], 2'd0}]);
          rdata_d[1] = endian_fix(mem[{idx[IdxW-1:2], 2'd1}]);
          rdata_d[2] = endian_fix(mem[{idx[IdxW-1:2], 2'd2}]);
          rdata_d[3] = endian_fix(mem[{idx[IdxW-1:2], 2'd3}]);
        end
`ifdef L15_RSP_DELAY_EN
        cnt_d   = 8'(RespDelay - 1);
        state_d = S_DELAY;
`else
        state_d = S_RESP;
`endif
      end
`ifdef L15_RSP_DELAY_EN
      S_DELAY: begin
        if (cnt_q == 8'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 8'd1;
      end
`endif
      S_RESP: begin
        rtrn_val = 1'b1;
        if (rtrn_ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      rqtype_q <= '0;
      size_q   <= '0;
      tid_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
`ifdef L15_RSP_DELAY_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rqtype_q <= rqtype_d;
      size_q   <= size_d;
      tid_q    <= tid_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
`ifdef L15_RSP_DELAY_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Byte-enable write; a reset in the same cycle suppresses it.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

  assign req_ack_o         = req_ack;
  assign req_header_ack_o  = req_ack;
  assign rtrn_val_o        = rtrn_val;
  assign rtrn_returntype_o = rtype;
  assign rtrn_threadid_o   = tid_q;
  assign rtrn_data_0_o     = rdata_q[0];
  assign rtrn_data_1_o     = rdata_q[1];
  assign rtrn_data_2_o     = rdata_q[2];
  assign rtrn_data_3_o     = rdata_q[3];
  assign err_o             = err_q;

endmodule
`default_nettype wire

// File: tb/tb_l15_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_l15_mem_responder                                                     |
// | Randomized scoreboard bench with a big-endian byte-memory model.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_l15_mem_responder;

  localparam int MEMW      = 4096;
  localparam int RSP_DELAY = 4;
`ifdef L15_RSP_DELAY_EN
  localparam int LAT = 3 + RSP_DELAY;
`else
  localparam int LAT = 3;
`endif
  localparam logic [4:0] T_LOAD = 5'b00000, T_IMISS = 5'b10000, T_STORE = 5'b00001;

  logic        clk = 1'b0;
  logic        rst_i, req_val_i, rtrn_ack_i;
  logic [4:0]  req_rqtype_i;
  logic [2:0]  req_size_i;
  logic [1:0]  req_threadid_i;
  logic [39:0] req_address_i;
  logic [63:0] req_data_i;
  logic        req_ack_o, req_header_ack_o, rtrn_val_o, err_o;
  logic [3:0]  rtrn_returntype_o;
  logic [1:0]  rtrn_threadid_o;
  logic [63:0] rtrn_data_0_o, rtrn_data_1_o, rtrn_data_2_o, rtrn_data_3_o;

  always #5 clk = ~clk;

  l15_mem_responder #(.MemWords(MEMW), .SwapEndianess(1'b1), .RespDelay(RSP_DELAY)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_val_i(req_val_i), .req_rqtype_i(req_rqtype_i),
    .req_size_i(req_size_i), .req_threadid_i(req_threadid_i), .req_address_i(req_address_i),
    .req_data_i(req_data_i), .req_ack_o(req_ack_o), .req_header_ack_o(req_header_ack_o),
    .rtrn_val_o(rtrn_val_o), .rtrn_returntype_o(rtrn_returntype_o),
    .rtrn_threadid_o(rtrn_threadid_o), .rtrn_data_0_o(rtrn_data_0_o),
    .rtrn_data_1_o(rtrn_data_1_o), .rtrn_data_2_o(rtrn_data_2_o),
    .rtrn_data_3_o(rtrn_data_3_o), .rtrn_ack_i(rtrn_ack_i), .err_o(err_o)
  );

  typedef struct packed {
    logic [3:0]  rt;
    logic [1:0]  tid;
    logic [63:0] d0, d1, d2, d3;
    logic        err;
    int          raise;
    bit          chk_lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  mdl [MEMW*8];   // byte memory, big-endian word view
  logic        mdl_err;
  int          checks = 0, failures = 0, cyc = 0;
  int          ack_mode = 2;    // 0 random, 1 hold low, 2 hold high
  int          last_acc_cyc = 0;
  bit          seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic logic [63:0] mdl_word(input int w);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[63-8*j -: 8] = mdl[(w % MEMW)*8 + j];
    return r;
  endfunction

  // Applies a request to the model and returns the response it must produce.
  function automatic exp_t model(input logic [4:0] t, input logic [2:0] sz,
                                 input logic [39:0] a, input logic [63:0] d, input logic [1:0] tid);
    exp_t   e;
    longint ba;
    int     w, lo, n, off;
    ba = longint'(a);
    w  = int'((ba >> 3) % MEMW);
    lo = int'(ba % 8);
    e  = '0;
    e.tid = tid;
    if (t == T_STORE) begin
      n   = 1 << sz;
      off = (lo / n) * n;
      for (int i = 0; i < n; i++) mdl[w*8 + off + i] = d[63-8*(off+i) -: 8];
      e.rt = 4'b0100;
    end else if (t == T_LOAD) begin
      e.rt = 4'b0000;
      e.d0 = mdl_word(w - w % 2);
      e.d1 = mdl_word(w - w % 2 + 1);
    end else if (t == T_IMISS) begin
      e.rt = 4'b0001;
      e.d0 = mdl_word(w - w % 4);
      e.d1 = mdl_word(w - w % 4 + 1);
      e.d2 = mdl_word(w - w % 4 + 2);
      e.d3 = mdl_word(w - w % 4 + 3);
    end else begin
      e.rt    = 4'b0100;
      mdl_err = 1'b1;
    end
    e.err = mdl_err;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_i && rtrn_val_o) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rtrn actual=1 required=0");
      end else begin
        mon_e = sb[0];
        if (!seen) begin
          seen = 1'b1;
          if (mon_e.chk_lat) chk("latency", 64'(cyc - mon_e.raise), 64'(LAT));
        end
        chk("returntype", 64'(rtrn_returntype_o), 64'(mon_e.rt));
        chk("threadid", 64'(rtrn_threadid_o), 64'(mon_e.tid));
        chk("data_0", rtrn_data_0_o, mon_e.d0);
        chk("data_1", rtrn_data_1_o, mon_e.d1);
        chk("data_2", rtrn_data_2_o, mon_e.d2);
        chk("data_3", rtrn_data_3_o, mon_e.d3);
        chk("err", 64'(err_o), 64'(mon_e.err));
        if (rtrn_ack_i) begin
          void'(sb.pop_front());
          seen = 1'b0;
          last_acc_cyc = cyc;
        end
      end
    end
  end

  initial begin
    rtrn_ack_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ack_mode)
        0:       rtrn_ack_i = ($urandom_range(0, 2) != 0);
        1:       rtrn_ack_i = 1'b0;
        default: rtrn_ack_i = 1'b1;
      endcase
    end
  end

  task automatic issue(input logic [4:0] t, input logic [2:0] sz, input logic [39:0] a,
                       input logic [63:0] d, input logic [1:0] tid, output int ack_cyc);
    exp_t e;
    bit   idle;
    int   k;
    idle = (sb.size() == 0);
    e = model(t, sz, a, d, tid);
    @(negedge clk);
    req_rqtype_i = t; req_size_i = sz; req_address_i = a; req_data_i = d;
    req_threadid_i = tid; req_val_i = 1'b1;
    e.raise = cyc; e.chk_lat = idle;
    sb.push_back(e);
    k = 0;
    do begin @(negedge clk); k++; end while (!req_ack_o && k < 300);
    ack_cyc = cyc;
    chk("req_ack_seen", 64'(req_ack_o), 64'd1);
    chk("hdr_ack", 64'(req_header_ack_o), 64'd1);
    if (idle) chk("ack_cycle", 64'(ack_cyc - e.raise), 64'd1);
    req_val_i = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 500) begin @(negedge clk); k++; end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    sb.delete(); seen = 1'b0; mdl_err = 1'b0;
    @(negedge clk);
    chk("rst_val", 64'(rtrn_val_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_data0", rtrn_data_0_o, 64'd0);
    rst_i = 1'b0;
  endtask

  initial begin
    int ac, ac_b, k;
    logic [4:0] t;
    rst_i = 1'b1; req_val_i = 1'b0; req_rqtype_i = '0; req_size_i = '0;
    req_threadid_i = '0; req_address_i = '0; req_data_i = '0; mdl_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ack", 64'(req_ack_o), 64'd0);
    chk("rst_hdr_ack", 64'(req_header_ack_o), 64'd0);
    chk("rst_rtrn_val", 64'(rtrn_val_o), 64'd0);
    chk("rst_rtype", 64'(rtrn_returntype_o), 64'd0);
    chk("rst_tid", 64'(rtrn_threadid_o), 64'd0);
    chk("rst_d0", rtrn_data_0_o, 64'd0);
    chk("rst_d1", rtrn_data_1_o, 64'd0);
    chk("rst_d2", rtrn_data_2_o, 64'd0);
    chk("rst_d3", rtrn_data_3_o, 64'd0);
    chk("rst_err_o", 64'(err_o), 64'd0);
    rst_i = 1'b0;

    for (int w = 0; w < 64; w++) issue(T_STORE, 3'd3, 40'(w*8), {$urandom, $urandom}, 2'(w), ac);
    wait_idle();

    issue(T_STORE, 3'd3, 40'h80, 64'h1122334455667788, 2'd1, ac); wait_idle();
    issue(T_LOAD, 3'd3, 40'h80, 64'd0, 2'd2, ac); wait_idle();
    issue(T_STORE, 3'd0, 40'h105, 64'hABAB_ABAB_ABAB_ABAB, 2'd3, ac); wait_idle();
    issue(T_LOAD, 3'd3, 40'h100, 64'd0, 2'd0, ac); wait_idle();
    for (int i = 0; i < 4; i++) issue(T_STORE, 3'd3, 40'(32 + 8*i), 64'(i + 1), 2'd1, ac);
    issue(T_IMISS, 3'd3, 40'h20, 64'd0, 2'd3, ac); wait_idle();

    // Return held for 10 cycles, then acknowledged.
    ack_mode = 1;
    issue(T_LOAD, 3'd3, 40'h40, 64'd0, 2'd2, ac);
    k = 0;
    while (!rtrn_val_o && k < 50) begin @(negedge clk); k++; end
    repeat (10) @(negedge clk);
    chk("hold_val", 64'(rtrn_val_o), 64'd1);
    ack_mode = 2;
    @(negedge clk);
    chk("ack_edge_val", 64'(rtrn_val_o & rtrn_ack_i), 64'd1);
    @(negedge clk);
    chk("post_ack_val", 64'(rtrn_val_o), 64'd0);
    wait_idle();

    // Request held high while busy is accepted two cycles after the return handshake.
    ack_mode = 0;
    issue(T_LOAD, 3'd3, 40'h48, 64'd0, 2'd1, ac);
    issue(T_IMISS, 3'd3, 40'h60, 64'd0, 2'd2, ac_b);
    chk("b2b_ack_cycle", 64'(ac_b), 64'(last_acc_cyc + 2));
    wait_idle();

    ack_mode = 2;
    issue(5'b00110, 3'd3, 40'h80, 64'hFFFF, 2'd3, ac); wait_idle();
    issue(T_LOAD, 3'd3, 40'h88, 64'd0, 2'd0, ac); wait_idle();
    do_reset();

    // Reset while the return is pending.
    ack_mode = 1;
    issue(T_LOAD, 3'd3, 40'h10, 64'd0, 2'd1, ac);
    k = 0;
    while (!rtrn_val_o && k < 50) begin @(negedge clk); k++; end
    chk("pre_rst_val", 64'(rtrn_val_o), 64'd1);
    rst_i = 1'b1; sb.delete(); seen = 1'b0; mdl_err = 1'b0;
    @(negedge clk);
    chk("rst_resp_val", 64'(rtrn_val_o), 64'd0);
    chk("rst_resp_d0", rtrn_data_0_o, 64'd0);
    rst_i = 1'b0;

    ack_mode = 0;
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 99);
      if (k < 40)      t = T_STORE;
      else if (k < 70) t = T_LOAD;
      else if (k < 95) t = T_IMISS;
      else begin
        t = 5'($urandom_range(0, 31));
        while (t == T_LOAD || t == T_STORE || t == T_IMISS) t = 5'($urandom_range(0, 31));
      end
      issue(t, 3'($urandom_range(0, 3)),
            40'($urandom_range(0, 63) * 8 + $urandom_range(0, 7)) | (40'($urandom) << 15),
            {$urandom, $urandom}, 2'($urandom_range(0, 3)), ac);
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/l15_mem_responder.md
Name: l15_mem_responder

Overview:
- Memory-side responder for the L1.5 request/return interface driven by the core's write-through cache subsystem.
- Accepts one request at a time (load, instruction fill, store) and services it from an internal word-addressed array.
- Returns the matching L1.5 return packet.
- Used as the far end of the core NOC port in standalone simulation and FPGA bring-up without the OpenPiton tile.

Parameters:
- MemWords, 4096, depth of backing array in 64-bit words (power of two, >= 4).
- SwapEndianess, 1, byte-reverse every 64-bit data word on store write and on return, matching big-endian L1.5 convention.
- RespDelay, 4, extra cycles inserted before a return when L15_RSP_DELAY_EN is defined (1..255).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_val_i  in  1  request valid (core's l15_val)
- req_rqtype_i  in  5  request type
- req_size_i  in  3  access size code
- req_threadid_i  in  2  transaction id
- req_address_i  in  40  byte address
- req_data_i  in  64  store data
- req_ack_o  out  1  request accepted
- req_header_ack_o  out  1  header accepted (asserted together with req_ack_o)
- rtrn_val_o  out  1  return valid
- rtrn_returntype_o  out  4  return type
- rtrn_threadid_o  out  2  echoed transaction id
- rtrn_data_0_o .. rtrn_data_3_o  out  64 each  return data words
- rtrn_ack_i  in  1  core accepted return (core's l15_req_ack)
- err_o  out  1  sticky: unsupported rqtype seen

Behaviour:
- Reset (rst_i=1 at posedge): FSM=IDLE.
  - All outputs 0: req_ack_o, req_header_ack_o, rtrn_val_o, returntype, threadid, data_0..3, err_o.
  - Array contents are not reset.
- Reset asserted mid-transaction: the transaction is dropped, outputs reach 0 at the next edge, and no array write occurs in that cycle.
- Encodings:
  - rqtype: LOAD=5'b00000, IMISS=5'b10000, STORE=5'b00001.
  - returntype: LOAD_RET=4'b0000, IFILL_RET=4'b0001, ST_ACK=4'b0100.
- Index: word index = address[3+log2(MemWords)-1:3]. Upper address bits are ignored, so accesses wrap modulo array size.
- FSM IDLE: on req_val_i=1, capture all request fields and go to ACCEPT. req_val_i=0 leaves the FSM in IDLE.
- FSM ACCEPT (exactly 1 cycle): req_ack_o=req_header_ack_o=1.
  - STORE: write the array this cycle.
  - Byte lanes from size (0=1B, 1=2B, 2=4B, 3=8B) and address[2:0]. Address is naturally aligned; misaligned low bits are masked down to the size.
  - Data placed in lane order after the optional swap.
  - Next state ACCESS.
- FSM ACCESS (1 cycle): synchronous array read.
  - LOAD reads the 16B-aligned pair (address[3]=0/1 words) into data_0/data_1; data_2/3=0.
  - IMISS reads the 32B-aligned group into data_0..3.
  - STORE reads nothing; data outputs are 0.
  - Next state RESP, or DELAY when the macro is enabled.
- FSM RESP: rtrn_val_o=1 with fields stable until rtrn_ack_i=1 is sampled.
  - On that edge rtrn_val_o drops and the FSM returns to IDLE.
  - A new request is not accepted in the same cycle: minimum 4 cycles request-to-request.
- Unsupported rqtype:
  - Still acked in ACCEPT with no array write.
  - err_o is set and held until reset.
  - Returns ST_ACK with zero data.
- rtrn_ack_i outside RESP is ignored. req_val_i held high during a busy period is serviced only after returning to IDLE.
- Latency, req_val_i rising to rtrn_val_o: 3 cycles (macro off).

Optional Feature:
- Macro: L15_RSP_DELAY_EN.
- Defined: adds a DELAY state between ACCESS and RESP.
  - An 8-bit down-counter is loaded with RespDelay-1 on entry and counts to 0; the FSM then moves to RESP.
  - Total latency becomes 3+RespDelay.
  - Reset clears the counter.
- Undefined: no DELAY state or counter; ACCESS goes directly to RESP.

Test Plan:
- Store size=3, addr 0x80, data 0x1122334455667788 (SwapEndianess=1), then LOAD addr 0x80 -> LOAD_RET, data_0=0x1122334455667788, data_1=word at 0x88, threadid echoed, rtrn_val 3 cycles after req_val.
- Store size=0, addr 0x105, data 0xAB in lane 5, then load 0x100 -> only byte 5 changed, other 7 bytes unchanged.
- IMISS addr 0x20 after preloading words 0x20..0x38 with 1,2,3,4 -> IFILL_RET, data_0..3=1,2,3,4.
- Hold rtrn_ack_i=0 for 10 cycles -> rtrn_val_o and all return fields stable; ack on cycle 11 -> IDLE next edge; back-to-back req_val accepted only afterwards.
- rqtype 5'b00110 -> acked, ST_ACK, err_o=1 sticky; rst_i pulse clears it. Reset asserted in RESP -> rtrn_val_o=0 next edge.
- With L15_RSP_DELAY_EN, RespDelay=4 -> load latency exactly 7 cycles.
